// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates NUM_PORTS cache-controller block requests onto one memory channel.
// Ports: CLK, RESET (sync, active-high); REQ_READ/REQ_WRITE/REQ_ADDRESS/REQ_WRITEDATA per-port
// requests with slices [i*W +: W]; REQ_READDATA shared registered read data; REQ_BUSYWAIT
// per-port stall; MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA drive memory, which answers
// with MEM_READDATA and the MEM_BUSYWAIT handshake.
module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int ARB_MODE   = 0
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [NUM_PORTS-1:0]             REQ_READ,
    input  logic [NUM_PORTS-1:0]             REQ_WRITE,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  REQ_ADDRESS,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  REQ_WRITEDATA,
    output logic [DATA_WIDTH-1:0]            REQ_READDATA,
    output logic [NUM_PORTS-1:0]             REQ_BUSYWAIT,
    output logic                             MEM_READ,
    output logic                             MEM_WRITE,
    output logic [ADDR_WIDTH-1:0]            MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0]            MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0]            MEM_READDATA,
    input  logic                             MEM_BUSYWAIT
);
    localparam int IW = $clog2(NUM_PORTS);
    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;
    state_t               state_q;
    logic [IW-1:0]        gnt_q, ptr_q, win_d;
    logic                 seen_q, rd_q, found;
    logic [NUM_PORTS-1:0] pend;
    assign pend = REQ_READ | REQ_WRITE;
    // Round-robin scans upward starting after the last served port; fixed priority keeps the lowest index.
    always_comb begin
        win_d = '0;
        found = 1'b0;
        if (ARB_MODE == 1) begin
            for (int j = NUM_PORTS - 1; j >= 0; j--)
                if (pend[IW'(j)]) win_d = IW'(j);
        end else begin
            for (int j = 1; j <= NUM_PORTS; j++)
                if (!found && pend[IW'((int'(ptr_q) + j) % NUM_PORTS)]) begin
                    found = 1'b1;
                    win_d = IW'((int'(ptr_q) + j) % NUM_PORTS);
                end
        end
    end
    assign MEM_ADDRESS   = REQ_ADDRESS[int'(gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign MEM_WRITEDATA = REQ_WRITEDATA[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
    assign MEM_WRITE     = (state_q == ISSUE) & REQ_WRITE[gnt_q];
    assign MEM_READ      = (state_q == ISSUE) & REQ_READ[gnt_q] & ~REQ_WRITE[gnt_q];
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_bw
        assign REQ_BUSYWAIT[i] = pend[i] & ~(state_q == COMPLETE && gnt_q == IW'(i));
    end
    // The read/write kind is latched at grant so a requester dropping its request
    // mid-access still gets its read data captured.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            seen_q       <= 1'b0;
            gnt_q        <= '0;
            ptr_q        <= IW'(NUM_PORTS - 1);
            rd_q         <= 1'b0;
            REQ_READDATA <= '0;
        end else begin
            case (state_q)
                IDLE: if (|pend) begin
                    gnt_q   <= win_d;
                    rd_q    <= REQ_READ[win_d] & ~REQ_WRITE[win_d];
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (MEM_BUSYWAIT) seen_q <= 1'b1;
                    if (seen_q && !MEM_BUSYWAIT) begin
                        state_q <= COMPLETE;
                        if (rd_q) REQ_READDATA <= MEM_READDATA;
                    end
                end
                COMPLETE: begin
                    ptr_q   <= gnt_q;
                    seen_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: round-robin and fixed-priority arbiters against a 5-cycle-busy memory model
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    typedef struct {bit rd; bit wr; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
    typedef struct {int port; bit wr; logic [AW-1:0] a; logic [DW-1:0] d; logic [DW-1:0] rdv;} exp_t;
    typedef struct {int k; bit rst; logic [1:0] act; logic [1:0] rd; logic [1:0] wr;
                    logic [AW-1:0] a0; logic [AW-1:0] a1; logic [DW-1:0] d0; logic [DW-1:0] d1; int first;} vec_t;
    logic            clk, rst;
    logic [1:0]      rd [2], wr [2], busy [2];
    logic [2*AW-1:0] addr [2];
    logic [2*DW-1:0] wd [2];
    logic [DW-1:0]   rdata [2], mwd [2], mrd [2];
    logic            mr [2], mw [2], mb [2];
    logic [AW-1:0]   ma [2];
    op_t             pq [4][$];
    exp_t            eq [2][$];
    logic [DW-1:0]   last [2];
    int              pass_n = 0, total_n = 0;
    int              cnt [2], len [2];
    bit              prev [2], skip [2];
    vec_t            vt [9];

    mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)) u_rr (
        .CLK(clk), .RESET(rst), .REQ_READ(rd[0]), .REQ_WRITE(wr[0]), .REQ_ADDRESS(addr[0]),
        .REQ_WRITEDATA(wd[0]), .REQ_READDATA(rdata[0]), .REQ_BUSYWAIT(busy[0]), .MEM_READ(mr[0]),
        .MEM_WRITE(mw[0]), .MEM_ADDRESS(ma[0]), .MEM_WRITEDATA(mwd[0]), .MEM_READDATA(mrd[0]),
        .MEM_BUSYWAIT(mb[0]));
    mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)) u_fp (
        .CLK(clk), .RESET(rst), .REQ_READ(rd[1]), .REQ_WRITE(wr[1]), .REQ_ADDRESS(addr[1]),
        .REQ_WRITEDATA(wd[1]), .REQ_READDATA(rdata[1]), .REQ_BUSYWAIT(busy[1]), .MEM_READ(mr[1]),
        .MEM_WRITE(mw[1]), .MEM_ADDRESS(ma[1]), .MEM_WRITEDATA(mwd[1]), .MEM_READDATA(mrd[1]),
        .MEM_BUSYWAIT(mb[1]));

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return (a == 28'h0000010) ? 128'hDEADBEEF_00000001_00000002_00000003 : {4{4'h0, a}};
    endfunction
    assign mrd[0] = mem_val(ma[0]);
    assign mrd[1] = mem_val(ma[1]);

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        total_n++;
        if (act === exp_v) pass_n++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Memory: busywait rises the cycle after a request appears, stays up 5 cycles, then drops.
    initial begin : mem_model
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0;
            mb[k]  = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                cnt[k] = (rst || !(mr[k] || mw[k])) ? 0 : cnt[k] + 1;
                mb[k]  = (cnt[k] >= 2) && (cnt[k] <= 6);
            end
        end
    end

    // Scoreboard checks at memory-request start and at completion, then requesters advance.
    initial begin : monitor
        exp_t e;
        op_t  o;
        bit   m;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 0; wr[k] = 0; addr[k] = '0; wd[k] = '0;
            prev[k] = 0; len[k] = 0; skip[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                m = mr[k] | mw[k];
                if (m && !prev[k]) begin
                    if (eq[k].size() == 0) begin
                        total_n++;
                        $display("FAIL start_k%0d: got memory request, expected none", k);
                    end else begin
                        e = eq[k][0];
                        check($sformatf("mem_addr_k%0d", k), DW'(ma[k]), DW'(e.a));
                        check($sformatf("mem_write_k%0d", k), DW'(mw[k]), DW'(e.wr));
                        check($sformatf("mem_read_k%0d", k), DW'(mr[k]), DW'(!e.wr));
                        check($sformatf("mem_wdata_k%0d", k), mwd[k], e.d);
                    end
                end
                if (rst && m) skip[k] = 1;
                if (m) len[k]++;
                if (!m && prev[k]) begin
                    if (!skip[k]) check($sformatf("req_cycles_k%0d", k), DW'(len[k]), DW'(7));
                    len[k]  = 0;
                    skip[k] = 0;
                end
                prev[k] = m;
                for (int p = 0; p < 2; p++)
                    if ((rd[k][p] | wr[k][p]) && !busy[k][p]) begin
                        if (eq[k].size() == 0) begin
                            total_n++;
                            $display("FAIL complete_k%0d: got completion on port %0d, expected none", k, p);
                        end else begin
                            e = eq[k].pop_front();
                            check($sformatf("grant_port_k%0d", k), DW'(p), DW'(e.port));
                            check($sformatf("readdata_k%0d", k), rdata[k], e.rdv);
                        end
                    end
                for (int p = 0; p < 2; p++)
                    if (!(rd[k][p] | wr[k][p]) || !busy[k][p]) begin
                        if (pq[k*2+p].size() != 0) begin
                            o = pq[k*2+p].pop_front();
                            rd[k][p] = o.rd;
                            wr[k][p] = o.wr;
                            addr[k][p*AW +: AW] = o.a;
                            wd[k][p*DW +: DW] = o.d;
                        end else begin
                            rd[k][p] = 0;
                            wr[k][p] = 0;
                        end
                    end
            end
        end
    end

    task automatic push_op(input int k, input int p, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.rd = r; o.wr = w; o.a = a; o.d = d;
        pq[k*2+p].push_back(o);
    endtask

    task automatic push_exp(input int k, input int p, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        last[k] = w ? last[k] : mem_val(a);
        e.port = p; e.wr = w; e.a = a; e.d = d; e.rdv = last[k];
        eq[k].push_back(e);
    endtask

    task automatic do_reset();
        rst = 1;
        last[0] = '0;
        last[1] = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
    endtask

    task automatic drain(input int k);
        int t = 0;
        while ((eq[k].size() != 0 || pq[k*2].size() != 0 || pq[k*2+1].size() != 0 ||
                rd[k] != 0 || wr[k] != 0) && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (t >= 400) begin
            total_n++;
            $display("FAIL drain_k%0d: got %0d transactions outstanding, expected 0", k, eq[k].size());
            eq[k].delete();
            pq[k*2].delete();
            pq[k*2+1].delete();
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin : test
        int q;
        int t;
        rst = 1;
        vt[0] = '{0, 1'b1, 2'b01, 2'b01, 2'b00, 28'h0000010, 28'h0, 128'h0, 128'h0, 0};
        vt[1] = '{0, 1'b1, 2'b11, 2'b11, 2'b00, 28'h100, 28'h200, 128'h11, 128'h22, 0};
        vt[2] = '{0, 1'b0, 2'b11, 2'b10, 2'b01, 28'h300, 28'h400, 128'hCAFE_0000_1234, 128'h33, 0};
        vt[3] = '{0, 1'b0, 2'b10, 2'b10, 2'b10, 28'h0, 28'h0000020, 128'h0, {16{8'hA5}}, 1};
        vt[4] = '{0, 1'b0, 2'b01, 2'b01, 2'b00, 28'h500, 28'h0, 128'h44, 128'h0, 0};
        vt[5] = '{0, 1'b0, 2'b11, 2'b11, 2'b00, 28'h600, 28'h700, 128'h55, 128'h66, 1};
        vt[6] = '{1, 1'b1, 2'b11, 2'b11, 2'b00, 28'h800, 28'h900, 128'h77, 128'h88, 0};
        vt[7] = '{1, 1'b0, 2'b01, 2'b01, 2'b00, 28'hA00, 28'h0, 128'h99, 128'h0, 0};
        vt[8] = '{1, 1'b0, 2'b11, 2'b00, 2'b11, 28'hB00, 28'hC00, 128'hAA, 128'hBB, 0};
        do_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_mem_read_k%0d", k), DW'(mr[k]), DW'(0));
            check($sformatf("rst_mem_write_k%0d", k), DW'(mw[k]), DW'(0));
            check($sformatf("rst_readdata_k%0d", k), rdata[k], DW'(0));
            check($sformatf("rst_busywait_k%0d", k), DW'(busy[k]), DW'(0));
        end
        for (int i = 0; i < 9; i++) begin
            if (vt[i].rst) do_reset();
            for (int p = 0; p < 2; p++)
                if (vt[i].act[p])
                    push_op(vt[i].k, p, vt[i].rd[p], vt[i].wr[p],
                            p ? vt[i].a1 : vt[i].a0, p ? vt[i].d1 : vt[i].d0);
            for (int j = 0; j < 2; j++) begin
                q = j ? 1 - vt[i].first : vt[i].first;
                if (vt[i].act[q])
                    push_exp(vt[i].k, q, vt[i].wr[q], q ? vt[i].a1 : vt[i].a0, q ? vt[i].d1 : vt[i].d0);
            end
            drain(vt[i].k);
        end
        // Fixed priority: port 0 keeps re-requesting, port 1 must wait until port 0 goes quiet.
        for (int j = 0; j < 3; j++) push_op(1, 0, 1'b1, 1'b0, 28'hD00 + 28'(j*16), 128'h0);
        push_op(1, 1, 1'b1, 1'b0, 28'hE00, 128'h0);
        for (int j = 0; j < 3; j++) push_exp(1, 0, 1'b0, 28'hD00 + 28'(j*16), 128'h0);
        push_exp(1, 1, 1'b0, 28'hE00, 128'h0);
        drain(1);
        // Reset during the third ISSUE cycle of a port-0 read; the read is then redone from scratch.
        push_op(0, 0, 1'b1, 1'b0, 28'h55, 128'h0);
        push_exp(0, 0, 1'b0, 28'h55, 128'h0);
        t = 0;
        while (!mr[0] && t < 20) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("mid_rst_issue_seen", DW'(t < 20), DW'(1));
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        rst = 1;
        last[1] = '0;
        @(posedge clk);
        #2;
        rst = 0;
        #1;
        check("mid_rst_mem_read", DW'(mr[0]), DW'(0));
        check("mid_rst_mem_write", DW'(mw[0]), DW'(0));
        check("mid_rst_readdata", rdata[0], DW'(0));
        check("mid_rst_busywait", DW'(busy[0]), DW'(2'b01));
        drain(0);
        check("end_mem_read_k0", DW'(mr[0]), DW'(0));
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take the following parameters, one per line: name, default, meaning.
- NUM_PORTS, 2, number of requesters (cache controllers); legal range 2..8.
- ADDR_WIDTH, 28, block address width.
- DATA_WIDTH, 128, block data width.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- CLK, in, 1, single clock; all state changes on its rising edge.
- RESET, in, 1, synchronous, active-high reset.
- REQ_READ, in, NUM_PORTS, per-port block read request.
- REQ_WRITE, in, NUM_PORTS, per-port block write request.
- REQ_ADDRESS, in, NUM_PORTS*ADDR_WIDTH, per-port address; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- REQ_WRITEDATA, in, NUM_PORTS*DATA_WIDTH, per-port write data; slices as above.
- REQ_READDATA, out, DATA_WIDTH, registered read data shared by all ports.
- REQ_BUSYWAIT, out, NUM_PORTS, per-port stall.
- MEM_READ, out, 1, read request to memory.
- MEM_WRITE, out, 1, write request to memory.
- MEM_ADDRESS, out, ADDR_WIDTH, address to memory.
- MEM_WRITEDATA, out, DATA_WIDTH, write data to memory.
- MEM_READDATA, in, DATA_WIDTH, read data from memory.
- MEM_BUSYWAIT, in, 1, memory stall.
REQ-003 Reset SHALL be synchronous and active-high on RESET, sampled on the CLK rising edge.

Function
REQ-004 A port is pending when REQ_READ[i] or REQ_WRITE[i] is 1.
REQ-005 Requesters SHALL hold their address and data stable while their REQ_BUSYWAIT bit is 1.
REQ-006 The FSM SHALL have exactly three states.
- IDLE: no memory access in flight.
- ISSUE: memory request driven; waiting for memory.
- COMPLETE: one-cycle completion.
REQ-007 IDLE:
- If any port is pending, latch the winner into the grant index GNT and go to ISSUE.
- If no port is pending, stay in IDLE.
REQ-008 Winner selection when ARB_MODE=0: the first pending port searching upward from (PTR+1) mod NUM_PORTS, where PTR is the last-served port.
REQ-009 Winner selection when ARB_MODE=1: the lowest-indexed pending port. PTR is ignored.
REQ-010 In ISSUE, the memory request SHALL be driven from port GNT.
- MEM_ADDRESS and MEM_WRITEDATA follow port GNT.
- MEM_WRITE = REQ_WRITE[GNT].
- MEM_READ = REQ_READ[GNT] & ~REQ_WRITE[GNT]; if both are 1, the write wins.
REQ-011 In IDLE and COMPLETE, MEM_READ and MEM_WRITE SHALL be 0.
REQ-012 ISSUE SHALL keep an internal flag SEEN.
- SEEN is set when MEM_BUSYWAIT=1.
- Go to COMPLETE on the first cycle with SEEN=1 and MEM_BUSYWAIT=0.
- A memory that never raises MEM_BUSYWAIT stalls the arbiter; this is legal but not recoverable except by reset.
REQ-013 On the ISSUE->COMPLETE edge, for a read, REQ_READDATA SHALL be loaded with MEM_READDATA; otherwise it holds its value.
REQ-014 COMPLETE SHALL:
- set PTR to GNT;
- clear SEEN;
- go to IDLE unconditionally.
Minimum request-to-request spacing is therefore one IDLE cycle.
REQ-015 REQ_BUSYWAIT[i] SHALL be combinational: (REQ_READ[i] | REQ_WRITE[i]) & ~(state==COMPLETE & GNT==i).
REQ-016 A granted port that drops its request during ISSUE SHALL NOT abort the transaction.
- The memory access completes.
- Read data is still captured.
- COMPLETE is still visited.
REQ-017 Requests arriving at other ports during ISSUE or COMPLETE SHALL wait.
- Their busywait stays 1.
- They are arbitrated in the next IDLE.
REQ-018 With ARB_MODE=0, no pending port SHALL wait more than NUM_PORTS-1 grants to other ports.

Reset
REQ-019 While RESET=1 at a rising edge, the block SHALL load:
- state = IDLE;
- SEEN = 0;
- GNT = 0;
- PTR = NUM_PORTS-1, so port 0 wins first in round-robin;
- REQ_READDATA = 0.
REQ-020 After that edge, MEM_READ=0 and MEM_WRITE=0.
REQ-021 Reset mid-transaction SHALL abandon the transaction.
- No data is captured.
- The block is in IDLE on the next edge.
- REQ_BUSYWAIT bits follow REQ-015 with state=IDLE, i.e. stay 1 for pending ports.

Verification
All scenarios use NUM_PORTS=2 and a memory model that raises MEM_BUSYWAIT one cycle after a request, holds it 5 cycles, then drops it.
REQ-022 Single read.
- Stimulus: port 0 reads address 0x0000010; memory returns 0xDEADBEEF_00000001_00000002_00000003.
- Expect MEM_READ for 7 cycles.
- Expect REQ_READDATA = that value in COMPLETE.
- Expect REQ_BUSYWAIT[0] low exactly in COMPLETE.
REQ-023 Simultaneous requests, ARB_MODE=0.
- Stimulus: both ports request at the same cycle, out of reset.
- Expect port 0 served, then port 1.
- Expect the next simultaneous pair served port 0 first again (PTR=1).
REQ-024 Fixed priority, ARB_MODE=1.
- Stimulus: port 0 requests continuously, port 1 requests once.
- Expect port 1 never granted while port 0 is pending.
- Expect port 1 granted in the first IDLE where port 0 is idle.
REQ-025 Read and write on the same port.
- Stimulus: port 1 asserts REQ_READ=1 and REQ_WRITE=1, data 0xA5A5...A5, address 0x0000020.
- Expect MEM_WRITE=1, MEM_READ=0, MEM_WRITEDATA=0xA5A5...A5.
- Expect REQ_READDATA unchanged.
REQ-026 Reset mid-transaction.
- Stimulus: RESET=1 for one cycle during the 3rd ISSUE cycle of a port-0 read.
- Expect state IDLE next edge and REQ_READDATA=0.
- Expect the still-pending port 0 re-granted after reset deasserts.
